// File: rtl/sccb_responder.sv
// sccb_responder: OV7670 SCCB target model; oversamples SIO_C/SIO_D and decodes
// 3-phase writes, 2-phase writes and 2-phase reads into a register-file port.
module sccb_responder #(
  parameter logic [6:0] DEV_ID = 7'h21,
  parameter bit         ACK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pwdn,
  input  logic       sio_c,
  input  logic       sio_d_i,
  output logic       sio_d_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);
  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_ID_ACK, S_SUB, S_SUB_ACK, S_DATA, S_DATA_ACK, S_RD, S_RD_NA, S_IGNORE
  } state_t;
  state_t state_q, state_d;
  logic [2:0] sc_q, sc_d, sd_q, sd_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, addr_q, addr_d, wdata_q, wdata_d;
  logic       rd_q, rd_d, oe_q, oe_d, busy_q, busy_d, we_q, we_d, re_q, re_d;
  logic       sc_rise, sc_fall, bus_start, bus_stop;
  logic [7:0] byte_in;
  // [1] is the synchronized level, [2] its one-clk delay for edge detection
  assign sc_d      = {sc_q[1:0], sio_c};
  assign sd_d      = {sd_q[1:0], sio_d_i};
  assign sc_rise   = sc_q[1] & ~sc_q[2];
  assign sc_fall   = ~sc_q[1] & sc_q[2];
  assign bus_start = sc_q[1] & sc_q[2] & ~sd_q[1] & sd_q[2];
  assign bus_stop  = sc_q[1] & sc_q[2] & sd_q[1] & ~sd_q[2];
  assign byte_in   = {shift_q[6:0], sd_q[1]};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    if (pwdn) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (bus_start) begin
      state_d = S_ID;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b1;
    end else if (bus_stop) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_ID, S_SUB, S_DATA: if (sc_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            if (state_q == S_SUB) begin
              addr_d  = byte_in;
              state_d = S_SUB_ACK;
            end else if (state_q == S_DATA) begin
              wdata_d = byte_in;
              we_d    = 1'b1;
              state_d = S_DATA_ACK;
            end else if (byte_in[7:1] == DEV_ID) begin
              rd_d    = byte_in[0];
              re_d    = byte_in[0];
              state_d = S_ID_ACK;
            end else state_d = S_IGNORE;
          end
        end
        S_ID_ACK, S_SUB_ACK, S_DATA_ACK: if (sc_fall) begin
          // first falling edge opens the ack slot, the second closes it
          if (cnt_q == 4'd0) begin
            oe_d  = ACK_EN;
            cnt_d = 4'd1;
          end else begin
            oe_d    = 1'b0;
            cnt_d   = '0;
            state_d = state_q == S_SUB_ACK ? S_DATA : state_q == S_DATA_ACK ? S_IGNORE : S_SUB;
            if (state_q == S_ID_ACK && rd_q) begin
              oe_d    = ~reg_rdata[7];
              shift_d = {reg_rdata[6:0], 1'b0};
              cnt_d   = 4'd1;
              state_d = S_RD;
            end
          end
        end
        S_RD: if (sc_fall) begin
          oe_d    = cnt_q == 4'd8 ? 1'b0 : ~shift_q[7];
          shift_d = {shift_q[6:0], 1'b0};
          cnt_d   = cnt_q + 4'd1;
          state_d = cnt_q == 4'd8 ? S_RD_NA : S_RD;
        end
        S_RD_NA: state_d = sc_rise ? S_IGNORE : S_RD_NA;
        S_IGNORE: oe_d = 1'b0;
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sc_q    <= '1;
      sd_q    <= '1;
      cnt_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      sd_q    <= sd_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      re_q    <= re_d;
    end
  end
  assign sio_d_oe  = oe_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = busy_q;
endmodule
